hex_dump_formatter: RTL and testbench
=====================================

HEX_DUMP_FORMATTER -- requirements
Module: hex_dump_formatter

Interface
REQ-001 Parameter BYTES_PER_LINE, default 16, data bytes per output line; legal range 1..255.
REQ-002 Parameter ADDR_PREFIX, default 1; 1 = each line starts with a 4-digit address and ": ", 0 = no prefix.
REQ-003 clk  in  1  single clock for all state.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_data  in  8  byte from ufm_reader (ufm_data).
REQ-006 in_addr  in  15  UFM byte address of in_data, sampled only on the first byte of a line.
REQ-007 in_valid  in  1  in_data/in_addr valid (ufm_valid).
REQ-008 in_ready  out  1  block can accept a byte this cycle; gates ufm_reader read_en.
REQ-009 flush  in  1  request to terminate a partial line.
REQ-010 tx_data  out  8  ASCII character to the uart (in_data of uart.wr path).
REQ-011 tx_wr  out  1  one-cycle write strobe to the uart.
REQ-012 tx_empty  in  1  uart transmitter free; drops no later than one cycle after tx_wr.

Function
REQ-013 A byte SHALL be consumed only in a cycle where in_valid and in_ready are both high; in_ready SHALL be high only in IDLE.
REQ-014 Per byte, output SHALL be: [prefix if column 0] HI LO, then " " if more bytes remain in the line, or CR (0x0D) LF (0x0A) if the byte completes the line.
REQ-015 Prefix SHALL be four uppercase hex digits of {1'b0, in_addr}, then ':' (0x3A), then ' ' (0x20).
REQ-016 Hex digits SHALL be uppercase: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-017 FSM states: IDLE, ADDR (digit counter 3..0), COLON, PSP, HI, LO, SEP, CR, LF; each non-IDLE state emits exactly one character.
REQ-018 Transitions: IDLE -> ADDR (prefix, column 0) or HI; ADDR -> COLON after digit 0; COLON -> PSP -> HI; HI -> LO; LO -> SEP or CR; SEP -> IDLE; CR -> LF -> IDLE.
REQ-019 Column counter (8 bits) SHALL increment on each consumed byte and clear to 0 after LF; line completes when the pre-increment column equals BYTES_PER_LINE-1.
REQ-020 A character SHALL be emitted by a one-cycle tx_wr with tx_data valid that cycle, only when tx_empty is high and the holdoff flag is clear.
REQ-021 After each tx_wr, a one-cycle holdoff SHALL block the next tx_wr, so a stale tx_empty is never used.
REQ-022 tx_data SHALL hold its last value between strobes.
REQ-023 flush high in IDLE with column != 0 SHALL go to CR, emit CR LF, then clear column; with column == 0 it is ignored.
REQ-024 flush asserted outside IDLE SHALL set a pending flag, served on the next IDLE entry before any new byte is accepted (in_ready low while pending).
REQ-025 Simultaneous in_valid and flush in IDLE: the flush SHALL win; the byte stays offered and is taken after LF.
REQ-026 Latency: first tx_wr no earlier than one cycle after byte acceptance; BYTES_PER_LINE=1 SHALL give prefix, HI, LO, CR, LF per byte.

Reset
REQ-027 When rst is low: state=IDLE, column=0, pending=0, holdoff=0, tx_wr=0, tx_data=0x00, in_ready=0; the first cycle after release may assert in_ready.
REQ-028 Reset mid-line SHALL discard the partial line with no CR/LF emitted; output restarts at column 0.

Structure
REQ-029 ASCII constants (CR, LF, colon, space) and the FSM state encoding SHALL live in a shared package for the UFM utilities.
REQ-030 The nibble-to-ASCII conversion SHALL be one combinational sub-module, nibble_to_ascii, instantiated once and muxed.

Verification
REQ-031 Prefix on, BPL=16, addr 0x7FA0, bytes 0x00..0x0F, tx_empty tied high -> "7FA0: 00 01 ... 0F\r\n", 55 strobes, none in consecutive cycles.
REQ-032 BPL=4, ADDR_PREFIX=0, bytes 0xDE 0xAD, then flush -> "DE AD\r\n"; a flush at column 0 -> no output.
REQ-033 tx_empty held low 20 cycles mid-line -> no tx_wr during the stall, no character lost or duplicated, in_ready low throughout.
REQ-034 flush and in_valid (0xAB) in the same IDLE cycle at column 2 -> CR LF first, then 0xAB taken as column 0 with a new prefix.
REQ-035 rst low after "7FA0: 1" is emitted -> all outputs at reset values; next byte 0x5C at addr 0x0010 -> "0010: 5C".
REQ-036 BPL=1, bytes 0xFF 0x0A -> "xxxx: FF\r\nxxxx: 0A\r\n" with the correct addresses.

Source files
------------

// File: rtl/hex_dump_formatter_pkg.sv
// rtl/hex_dump_formatter_pkg.sv - shared ASCII constants and FSM encoding for the UFM utilities
package hex_dump_formatter_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_COLON,
        ST_PSP,
        ST_HI,
        ST_LO,
        ST_SEP,
        ST_CR,
        ST_LF
    } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - combinational 4-bit value to uppercase ASCII hex digit
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'd0, nibble};
        end else begin
            ascii = 8'h37 + {4'd0, nibble};
        end
    end

endmodule

// File: rtl/hex_dump_formatter.sv
// rtl/hex_dump_formatter.sv - turns a UFM byte stream into hex-dump text lines for the uart
module hex_dump_formatter
    import hex_dump_formatter_pkg::*;
#(
    parameter int BYTES_PER_LINE = 16,
    parameter int ADDR_PREFIX    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic [14:0] in_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_empty
);

    localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

    state_t      state;
    logic [1:0]  digit;
    logic [7:0]  column;
    logic        pending;
    logic        holdoff;
    logic        ready_q;
    logic        line_last;
    logic [7:0]  byte_q;
    logic [14:0] addr_q;

    logic [15:0] addr_word;
    logic [3:0]  nibble;
    logic [7:0]  hex_char;
    logic [7:0]  out_char;
    logic        fire;
    logic        flush_now;

    assign addr_word = {1'b0, addr_q};
    assign fire      = tx_empty && !holdoff;
    assign flush_now = (pending || flush) && (column != 8'd0);
    // A flush in IDLE must beat a simultaneously offered byte, hence the combinational gate.
    assign in_ready  = ready_q && !flush_now;

    always_comb begin
        case (state)
            ST_ADDR: nibble = addr_word[{digit, 2'b00} +: 4];
            ST_HI:   nibble = byte_q[7:4];
            default: nibble = byte_q[3:0];
        endcase
    end

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        case (state)
            ST_ADDR, ST_HI, ST_LO: out_char = hex_char;
            ST_COLON:              out_char = ASCII_COLON;
            ST_PSP, ST_SEP:        out_char = ASCII_SPACE;
            ST_CR:                 out_char = ASCII_CR;
            ST_LF:                 out_char = ASCII_LF;
            default:               out_char = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            digit     <= 2'd3;
            column    <= 8'd0;
            pending   <= 1'b0;
            holdoff   <= 1'b0;
            ready_q   <= 1'b0;
            line_last <= 1'b0;
            byte_q    <= 8'h00;
            addr_q    <= 15'd0;
            tx_wr     <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            tx_wr   <= 1'b0;
            holdoff <= 1'b0;
            if (state == ST_IDLE) begin
                ready_q <= 1'b1;
                if (flush_now) begin
                    state   <= ST_CR;
                    pending <= 1'b0;
                    ready_q <= 1'b0;
                end else begin
                    pending <= 1'b0;
                    if (in_valid && in_ready) begin
                        byte_q    <= in_data;
                        line_last <= (column == LAST_COL);
                        column    <= column + 8'd1;
                        digit     <= 2'd3;
                        ready_q   <= 1'b0;
                        if (column == 8'd0) begin
                            addr_q <= in_addr;
                        end
                        state <= ((ADDR_PREFIX != 0) && (column == 8'd0)) ? ST_ADDR : ST_HI;
                    end
                end
            end else begin
                if (flush) begin
                    pending <= 1'b1;
                end
                if (fire) begin
                    tx_wr   <= 1'b1;
                    tx_data <= out_char;
                    holdoff <= 1'b1;
                    case (state)
                        ST_ADDR: begin
                            if (digit == 2'd0) state <= ST_COLON;
                            else               digit <= digit - 2'd1;
                        end
                        ST_COLON: state <= ST_PSP;
                        ST_PSP:   state <= ST_HI;
                        ST_HI:    state <= ST_LO;
                        ST_LO:    state <= line_last ? ST_CR : ST_SEP;
                        ST_SEP: begin
                            state   <= ST_IDLE;
                            ready_q <= !(pending || flush);
                        end
                        ST_CR:    state <= ST_LF;
                        ST_LF: begin
                            state   <= ST_IDLE;
                            column  <= 8'd0;
                            ready_q <= !(pending || flush);
                        end
                        default:  state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_dump_formatter.sv
// tb/tb_hex_dump_formatter.sv - self-checking bench for hex_dump_formatter
module tb_hex_dump_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data  [3];
    logic [14:0] in_addr  [3];
    logic        in_valid [3];
    logic        in_ready [3];
    logic        flush    [3];
    logic [7:0]  tx_data  [3];
    logic        tx_wr    [3];
    logic        tx_empty [3];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] cap [3][$];
    logic [7:0] exp_q [$];
    logic [7:0] last_data [3] = '{8'h00, 8'h00, 8'h00};
    logic       prev_wr [3] = '{1'b0, 1'b0, 1'b0};
    int         m_col [3] = '{0, 0, 0};
    int         m_bpl [3] = '{16, 4, 1};
    int         m_pfx [3] = '{1, 0, 1};
    string      hexdig = "0123456789ABCDEF";

    always #5 clk = ~clk;

    hex_dump_formatter #(.BYTES_PER_LINE(16), .ADDR_PREFIX(1)) u_p16 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_addr(in_addr[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .flush(flush[0]),
        .tx_data(tx_data[0]), .tx_wr(tx_wr[0]), .tx_empty(tx_empty[0])
    );

    hex_dump_formatter #(.BYTES_PER_LINE(4), .ADDR_PREFIX(0)) u_n4 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_addr(in_addr[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .flush(flush[1]),
        .tx_data(tx_data[1]), .tx_wr(tx_wr[1]), .tx_empty(tx_empty[1])
    );

    hex_dump_formatter #(.BYTES_PER_LINE(1), .ADDR_PREFIX(1)) u_p1 (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_addr(in_addr[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .flush(flush[2]),
        .tx_data(tx_data[2]), .tx_wr(tx_wr[2]), .tx_empty(tx_empty[2])
    );

    // uart-side monitor: collect characters, police strobe spacing and tx_data hold
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                prev_wr[k]   = 1'b0;
                last_data[k] = 8'h00;
            end else begin
                if (tx_wr[k] === 1'b1) begin
                    vectors++;
                    assert (prev_wr[k] === 1'b0) else begin
                        miscompares++;
                        $error("FAIL back_to_back_wr inst%0d got 1 want 0", k);
                    end
                    cap[k].push_back(tx_data[k]);
                    last_data[k] = tx_data[k];
                end else if (prev_wr[k]) begin
                    vectors++;
                    assert (tx_data[k] === last_data[k]) else begin
                        miscompares++;
                        $error("FAIL tx_data_hold inst%0d got %h want %h", k, tx_data[k], last_data[k]);
                    end
                end
                prev_wr[k] = tx_wr[k];
            end
        end
    end

    function automatic void model_byte(input int k, input logic [7:0] d, input logic [14:0] a);
        int addr = int'(a);
        int dv = int'(d);
        if (m_col[k] == 0 && m_pfx[k] != 0) begin
            for (int s = 12; s >= 0; s -= 4) exp_q.push_back(hexdig[(addr >> s) % 16]);
            exp_q.push_back(8'h3A);
            exp_q.push_back(8'h20);
        end
        exp_q.push_back(hexdig[dv / 16]);
        exp_q.push_back(hexdig[dv % 16]);
        m_col[k]++;
        if (m_col[k] == m_bpl[k]) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            m_col[k] = 0;
        end else begin
            exp_q.push_back(8'h20);
        end
    endfunction

    function automatic void model_flush(input int k);
        if (m_col[k] != 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            m_col[k] = 0;
        end
    endfunction

    task automatic send(input int k, input logic [7:0] d, input logic [14:0] a);
        int t = 0;
        @(negedge clk);
        in_data[k]  = d;
        in_addr[k]  = a;
        in_valid[k] = 1'b1;
        while (in_ready[k] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        assert (t < 500) else begin
            miscompares++;
            $error("FAIL accept_timeout inst%0d got %0d cycles want <500", k, t);
        end
        @(negedge clk);
        in_valid[k] = 1'b0;
        model_byte(k, d, a);
    endtask

    task automatic flush_req(input int k);
        @(negedge clk);
        flush[k] = 1'b1;
        @(negedge clk);
        flush[k] = 1'b0;
        model_flush(k);
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        @(negedge clk);
        while (in_ready[k] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        assert (t < 500) else begin
            miscompares++;
            $error("FAIL idle_timeout inst%0d got %0d cycles want <500", k, t);
        end
        @(negedge clk);
    endtask

    task automatic check_stream(input int k, input string tag);
        int n;
        vectors++;
        assert (cap[k].size() === exp_q.size()) else begin
            miscompares++;
            $error("FAIL %s_len got %0d want %0d", tag, cap[k].size(), exp_q.size());
        end
        n = (cap[k].size() < exp_q.size()) ? cap[k].size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            assert (cap[k][i] === exp_q[i]) else begin
                miscompares++;
                $error("FAIL %s_char%0d got %h want %h", tag, i, cap[k][i], exp_q[i]);
            end
        end
        cap[k].delete();
        exp_q.delete();
    endtask

    initial begin
        int t;
        int n;
        for (int k = 0; k < 3; k++) begin
            in_data[k]  = 8'h00;
            in_addr[k]  = 15'd0;
            in_valid[k] = 1'b0;
            flush[k]    = 1'b0;
            tx_empty[k] = 1'b1;
        end

        // reset values
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            assert ({tx_wr[k], tx_data[k], in_ready[k]} === 10'd0) else begin
                miscompares++;
                $error("FAIL reset_outputs inst%0d got %b/%h/%b want 0/00/0", k, tx_wr[k], tx_data[k], in_ready[k]);
            end
        end
        rst = 1'b1;

        // full 16-byte line with address prefix
        for (int i = 0; i < 16; i++) send(0, 8'(i), 15'h7FA0 + 15'(i));
        wait_idle(0);
        vectors++;
        assert (cap[0].size() === 55) else begin
            miscompares++;
            $error("FAIL line16_strobes got %0d want 55", cap[0].size());
        end
        check_stream(0, "line16");

        // partial line closed by flush, then flush at column 0
        send(1, 8'hDE, 15'h0000);
        send(1, 8'hAD, 15'h0001);
        flush_req(1);
        wait_idle(1);
        check_stream(1, "flush_partial");
        flush_req(1);
        repeat (20) @(negedge clk);
        check_stream(1, "flush_col0");

        // uart stall mid-line
        send(0, 8'h3C, 15'h0100);
        wait_idle(0);
        send(0, 8'hC3, 15'h0101);
        tx_empty[0] = 1'b0;
        n = cap[0].size();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            assert (tx_wr[0] === 1'b0 && in_ready[0] === 1'b0) else begin
                miscompares++;
                $error("FAIL stall_cycle%0d got wr=%b rdy=%b want 0/0", i, tx_wr[0], in_ready[0]);
            end
        end
        vectors++;
        assert (cap[0].size() === n) else begin
            miscompares++;
            $error("FAIL stall_count got %0d want %0d", cap[0].size(), n);
        end
        tx_empty[0] = 1'b1;
        wait_idle(0);
        flush_req(0);
        wait_idle(0);
        check_stream(0, "stall");

        // flush and byte offered together at column 2
        send(0, 8'h11, 15'h0200);
        send(0, 8'h22, 15'h0201);
        wait_idle(0);
        @(negedge clk);
        in_data[0]  = 8'hAB;
        in_addr[0]  = 15'h0300;
        in_valid[0] = 1'b1;
        flush[0]    = 1'b1;
        #1;
        vectors++;
        assert (in_ready[0] === 1'b0) else begin
            miscompares++;
            $error("FAIL flush_wins_ready got %b want 0", in_ready[0]);
        end
        @(negedge clk);
        flush[0] = 1'b0;
        t = 0;
        while (in_ready[0] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        assert (t < 500) else begin
            miscompares++;
            $error("FAIL flush_byte_timeout got %0d want <500", t);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        model_flush(0);
        model_byte(0, 8'hAB, 15'h0300);
        flush_req(0);
        wait_idle(0);
        check_stream(0, "flush_and_byte");

        // reset in the middle of a line
        send(0, 8'h12, 15'h7FA0);
        t = 0;
        while (cap[0].size() < 7 && t < 200) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b0;
        vectors++;
        assert (cap[0].size() === 7) else begin
            miscompares++;
            $error("FAIL pre_reset_count got %0d want 7", cap[0].size());
        end
        n = (cap[0].size() < 7) ? cap[0].size() : 7;
        for (int i = 0; i < n; i++) begin
            vectors++;
            assert (cap[0][i] === exp_q[i]) else begin
                miscompares++;
                $error("FAIL pre_reset_char%0d got %h want %h", i, cap[0][i], exp_q[i]);
            end
        end
        #1;
        vectors++;
        assert ({tx_wr[0], tx_data[0], in_ready[0]} === 10'd0) else begin
            miscompares++;
            $error("FAIL midline_reset got %b/%h/%b want 0/00/0", tx_wr[0], tx_data[0], in_ready[0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_col[k] = 0;
            cap[k].delete();
        end
        exp_q.delete();
        send(0, 8'h5C, 15'h0010);
        flush_req(0);
        wait_idle(0);
        check_stream(0, "after_reset");

        // one byte per line
        send(2, 8'hFF, 15'h1234);
        send(2, 8'h0A, 15'h1235);
        wait_idle(2);
        check_stream(2, "bpl1");

        // randomized traffic against the reference model
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 30; i++) begin
                send(k, 8'($urandom), 15'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    tx_empty[k] = 1'b0;
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    tx_empty[k] = 1'b1;
                end
                if ($urandom_range(0, 4) == 0) begin
                    if ($urandom_range(0, 1) == 0) wait_idle(k);
                    flush_req(k);
                end
            end
            flush_req(k);
            wait_idle(k);
            check_stream(k, (k == 0) ? "rand_p16" : "rand_n4");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
